// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag generator for the asynchronous FIFO (write clock domain).
// Define FIFO_WPTR_ALMOST_FULL_EN to add the fill level and almost-full outputs.

`ifdef FIFO_WPTR_ALMOST_FULL_EN
module fifo_wptr_full_gray2bin #(
   parameter int SIZE = 5
) (
   input  logic [SIZE-1:0] gray_i,
   output logic [SIZE-1:0] bin_o
);

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin_o = '0;
      for (int i = 0; i < SIZE; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule
`endif

module fifo_wptr_full #(
   parameter int ADDR_SIZE = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 winc,
   input  logic [ADDR_SIZE:0]   wq2_rptr,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [ADDR_SIZE:0]   wptr,
   output logic                 wfull
`ifdef FIFO_WPTR_ALMOST_FULL_EN
   ,
   output logic [ADDR_SIZE:0]   wlevel,
   output logic                 walmost_full
`endif
);

   localparam int PW    = ADDR_SIZE + 1;
   localparam int DEPTH = 1 << ADDR_SIZE;

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic          wfull_q, wfull_d;
   logic          wwrite;

   assign wwrite = winc & ~wfull_q;
   assign wbin_d = wbin_q + PW'(wwrite);
   assign wptr_d = (wbin_d >> 1) ^ wbin_d;

   // Full when the writer is exactly one lap ahead: in Gray code that means the
   // top two bits differ and the rest match.
   assign wfull_d = (wptr_d == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]});

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         wfull_q <= wfull_d;
      end
   end

   assign waddr = wbin_q[ADDR_SIZE-1:0];
   assign wptr  = wptr_q;
   assign wfull = wfull_q;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
   localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

   logic [PW-1:0] rbin_s;
   logic [PW-1:0] wlevel_q, wlevel_d;
   logic          walmost_full_q, walmost_full_d;

   fifo_wptr_full_gray2bin #(
      .SIZE (PW)
   ) u_rptr_g2b (
      .gray_i (wq2_rptr),
      .bin_o  (rbin_s)
   );

   // Level is taken against the lagging read pointer, so it over-reports.
   assign wlevel_d       = wbin_d - rbin_s;
   assign walmost_full_d = (wlevel_d >= AF_THRESH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wlevel_q       <= '0;
         walmost_full_q <= 1'b0;
      end else begin
         wlevel_q       <= wlevel_d;
         walmost_full_q <= walmost_full_d;
      end
   end

   assign wlevel       = wlevel_q;
   assign walmost_full = walmost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: a count-based FIFO occupancy model feeds a
// scoreboard queue that a monitor drains after every write-clock edge.

module tb_fifo_wptr_full;

   localparam int ADDR_SIZE = 4;
   localparam int AF_MARGIN = 2;
   localparam int DEPTH     = 1 << ADDR_SIZE;

   typedef struct {
      logic [ADDR_SIZE:0]   wptr;
      logic [ADDR_SIZE-1:0] waddr;
      logic                 wfull;
      logic                 acc;
      logic [ADDR_SIZE:0]   level;
      logic                 af;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 winc = 1'b0;
   logic [ADDR_SIZE:0]   wq2_rptr = '0;
   logic [ADDR_SIZE-1:0] waddr;
   logic [ADDR_SIZE:0]   wptr;
   logic                 wfull;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
   logic [ADDR_SIZE:0]   wlevel;
   logic                 walmost_full;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: total writes accepted and total reads seen by the writer.
   int   wr_cnt   = 0;
   int   rd_cnt   = 0;
   logic exp_full = 1'b0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   fifo_wptr_full #(
      .ADDR_SIZE (ADDR_SIZE),
      .AF_MARGIN (AF_MARGIN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull)
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      ,
      .wlevel       (wlevel),
      .walmost_full (walmost_full)
`endif
   );

   function automatic logic [ADDR_SIZE:0] to_gray(input int n);
      logic [ADDR_SIZE:0] b;
      b = ADDR_SIZE'(0) + (ADDR_SIZE+1)'(n % (2 * DEPTH));
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One write-clock cycle of stimulus; the expected post-edge state goes to the scoreboard.
   task automatic step(input logic w, input logic rd_adv);
      exp_t e;
      @(negedge clk);
      winc = w;
      if (rd_adv && rd_cnt < wr_cnt) rd_cnt++;
      wq2_rptr = to_gray(rd_cnt);
      e.acc = w && !exp_full;
      if (e.acc) wr_cnt++;
      exp_full = ((wr_cnt - rd_cnt) == DEPTH);
      e.wptr  = to_gray(wr_cnt);
      e.waddr = ADDR_SIZE'(wr_cnt % DEPTH);
      e.wfull = exp_full;
      e.level = (ADDR_SIZE+1)'(wr_cnt - rd_cnt);
      e.af    = ((wr_cnt - rd_cnt) >= DEPTH - AF_MARGIN);
      sb_q.push_back(e);
   endtask

   // Asserts reset away from any clock edge and checks it takes effect without a clock.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      winc  = 1'b0;
      #1;
      check("rst_wptr", 32'(wptr), 32'd0);
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_wfull", 32'(wfull), 32'd0);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
      check("rst_wlevel", 32'(wlevel), 32'd0);
      check("rst_walmost_full", 32'(walmost_full), 32'd0);
`endif
      wr_cnt   = 0;
      rd_cnt   = 0;
      exp_full = 1'b0;
      wq2_rptr = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: drains the scoreboard after each edge and checks the single-bit Gray step.
   initial begin : monitor
      exp_t               e;
      logic [ADDR_SIZE:0] last_wptr;
      last_wptr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            last_wptr = '0;
         end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wptr", 32'(wptr), 32'(e.wptr));
            check("waddr", 32'(waddr), 32'(e.waddr));
            check("wfull", 32'(wfull), 32'(e.wfull));
            check("gray_step", 32'($countones(wptr ^ last_wptr)), e.acc ? 32'd1 : 32'd0);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
            check("wlevel", 32'(wlevel), 32'(e.level));
            check("walmost_full", 32'(walmost_full), 32'(e.af));
`endif
            last_wptr = wptr;
         end
      end
   end

   initial begin : stimulus
      do_reset();

      // Mid-stream reset, then the first write after release.
      repeat (5) step(1'b1, 1'b0);
      do_reset();
      step(1'b1, 1'b0);

      // Fill from empty, then a write while full.
      do_reset();
      repeat (16) step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("fill_wptr", 32'(wptr), 32'b11000);
      check("fill_waddr", 32'(waddr), 32'd0);
      check("fill_wfull", 32'(wfull), 32'd1);
      step(1'b1, 1'b0);

      // Write coinciding with the read pointer leaving full, then re-fill.
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("refill_wptr", 32'(wptr), 32'b11001);
      check("refill_wfull", 32'(wfull), 32'd1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);

      // Continuous writes across the pointer wrap with the reader trailing by 8.
      do_reset();
      for (int i = 0; i < 64; i++) step(1'b1, (wr_cnt - rd_cnt) >= 8);

`ifdef FIFO_WPTR_ALMOST_FULL_EN
      do_reset();
      repeat (13) step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("af13_level", 32'(wlevel), 32'd13);
      check("af13_flag", 32'(walmost_full), 32'd0);
      step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("af14_level", 32'(wlevel), 32'd14);
      check("af14_flag", 32'(walmost_full), 32'd1);
      repeat (2) step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("af16_level", 32'(wlevel), 32'd16);
      check("af16_full", 32'(wfull), 32'd1);
`endif

      // Random traffic biased toward writes so full is reached and released often.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 10) < 7, ($urandom % 3) == 0);
      end

      @(negedge clk);
      winc = 1'b0;
      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag generator for the asynchronous FIFO, in the write clock domain.
- Keeps the binary write counter and produces the RAM write address and the registered Gray write pointer that is sent to the read domain.
- Compares the next Gray pointer against the already-synchronized Gray read pointer to produce a registered full flag.
- Optional: converts the synchronized Gray read pointer back to binary (Gray-to-binary converter instance) to produce fill level and almost-full.

Parameters:
- ADDR_SIZE, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- AF_MARGIN, 2, almost-full threshold margin; used only with the optional feature; legal range 1..DEPTH-1.

Ports:
- clk  input  1  write-domain clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request from producer.
- wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already 2-flop synchronized into clk.
- waddr  output  ADDR_SIZE  binary RAM write address, equal to wbin[ADDR_SIZE-1:0].
- wptr  output  ADDR_SIZE+1  registered Gray write pointer, to the read-domain synchronizer.
- wfull  output  1  registered full flag.
- wlevel  output  ADDR_SIZE+1  fill level; present only with the optional feature.
- walmost_full  output  1  registered almost-full; present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - wbin=0, wptr=0, wfull=0.
  - With the feature: wlevel=0, walmost_full=0.
  - Release is synchronous to the next clk edge.
  - Reset mid-operation discards all state; the pointer restarts at 0 with no partial update.
- Write acceptance: wwrite = winc & ~wfull.
  - A write while wfull=1 is ignored: pointer, address and flags are unchanged.
- Next-state, combinational:
  - wbinnext = wbin + wwrite, modulo 2**(ADDR_SIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
- Registered on the rising clk edge: wbin<=wbinnext, wptr<=wgraynext.
  - Latency: waddr and wptr reflect an accepted write on the same edge that accepts it.
  - Exactly one Gray bit of wptr changes per accepted write, including wrap 31->0 (Gray 10000->00000 for ADDR_SIZE=4).
- Full detection:
  - wfull_next = (wgraynext == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
  - wfull <= wfull_next.
  - wfull asserts on the same edge as the DEPTH-th outstanding write.
  - wfull deasserts one clk edge after wq2_rptr advances.
  - Assertion is pessimistic by design because wq2_rptr lags the true read pointer.
- Simultaneous events:
  - winc at the edge where wq2_rptr advances out of full: the write is ignored, because wfull is still 1 in that cycle.
  - The next winc is accepted and may re-assert full.
- wq2_rptr must change by at most one Gray bit per clk; any other change is a protocol violation and the behaviour is undefined.
- No other state machine: the block is a pointer register plus two flag registers.

Optional Feature:
- Macro: FIFO_WPTR_ALMOST_FULL_EN.
- Defined:
  - Instantiate a Gray-to-binary converter (SIZE=ADDR_SIZE+1) on wq2_rptr, giving rbin_s.
  - wlevel_next = wbinnext - rbin_s, modulo 2**(ADDR_SIZE+1); range 0..DEPTH.
  - Registered: wlevel <= wlevel_next; walmost_full <= (wlevel_next >= DEPTH-AF_MARGIN).
  - Both reset to 0.
- Undefined: wlevel and walmost_full ports, the converter and the subtractor are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: assert rst_n=0 after 5 writes -> wptr=00000, waddr=0, wfull=0 immediately, with no clk needed; first write after release gives wptr=00001.
- Fill: wq2_rptr=00000, 16 consecutive winc -> after the 16th edge wptr=11000, waddr=0, wfull=1; a 17th winc leaves wptr=11000.
- Release from full: from full, set wq2_rptr=00001 -> wfull=0 one edge later; one winc -> wptr=11001, wfull=1 on that edge.
- Simultaneous: winc=1 held on the same edge wq2_rptr changes 00000->00001 while full -> write ignored (wptr stays 11000), wfull drops; the following winc is accepted.
- Wrap: with wq2_rptr trailing by 8, write continuously through wbin 31->0 -> wptr goes 10000->00000, a single-bit change; a checker confirms one Gray bit toggles per write for 64 writes.
- FIFO_WPTR_ALMOST_FULL_EN, AF_MARGIN=2, wq2_rptr=0: after 13 writes walmost_full=0, wlevel=13; after 14 writes walmost_full=1, wlevel=14; after 16 writes wlevel=16, wfull=1.
